// File: rtl/bip_pkg.sv
// Shared BIP definitions: loader FSM state encoding, default halt word
// and BIP opcode constants (5-bit opcode, 11-bit operand).
package bip_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [15:0] HLT_WORD = 16'h0000;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

endpackage

// File: rtl/byte_assembler.sv
// Packs MSB-first bytes into DATA_WIDTH words.
// Ports: clk, reset (sync, high), rx_data/accept in; word/word_valid out.
// word/word_valid are valid in the cycle the last byte is accepted.
module byte_assembler #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  accept,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_valid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    generate
        if (BYTES == 1) begin : g_single
            assign word       = rx_data;
            assign word_valid = accept;
        end else begin : g_multi
            logic [DATA_WIDTH-9:0] shreg;
            logic [CW-1:0]         cnt;
            logic                  last;

            assign last       = (cnt == CW'(BYTES - 1));
            assign word       = {shreg, rx_data};
            assign word_valid = accept && last;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else if (accept) begin
                    shreg <= word[DATA_WIDTH-9:0];
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bip_program_loader.sv
// BIP serial program loader: UART bytes -> program memory, CPU held in
// reset until the halt word is written. Ports: clk, reset, rx_data,
// rx_done in; prog_wr/addr/data, cpu_reset, done, error out (registered).
// Optional BIP_LOADER_CHECKSUM_EN: trailing XOR checksum byte after halt.
module bip_program_loader
    import bip_pkg::*;
#(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD = DATA_WIDTH'(HLT_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic                  prog_wr,
    output logic [ADDR_BITS-1:0]  prog_addr,
    output logic [DATA_WIDTH-1:0] prog_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

    state_t                  state, state_n;
    logic [ADDR_BITS-1:0]    addr, addr_n;
    logic                    wr_n, cpu_reset_n, done_n, error_n;
    logic [ADDR_BITS-1:0]    paddr_n;
    logic [DATA_WIDTH-1:0]   pdata_n;
    logic                    accept, word_valid;
    logic [DATA_WIDTH-1:0]   word;
    logic                    is_halt, at_max;

    // prog_data holds the word being written while in WRITE
    assign is_halt = (prog_data == HALT_WORD);
    assign at_max  = (addr == ADDR_MAX);

    // In WRITE, a byte only starts a new word if loading continues
    assign accept = rx_done &&
                    ((state == ST_LOAD) ||
                     ((state == ST_WRITE) && !is_halt && !at_max));

`ifdef BIP_LOADER_CHECKSUM_EN
    logic [7:0] xsum, xsum_n;
    logic       sum_ok;
    assign xsum_n = accept ? (xsum ^ rx_data) : xsum;
    assign sum_ok = (rx_data == xsum);
`endif

    byte_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .accept    (accept),
        .word      (word),
        .word_valid(word_valid)
    );

    always_comb begin
        state_n = state;
        addr_n  = addr;
        wr_n    = 1'b0;
        paddr_n = prog_addr;
        pdata_n = prog_data;
        case (state)
            ST_LOAD: begin
                if (word_valid) begin
                    state_n = ST_WRITE;
                    wr_n    = 1'b1;
                    paddr_n = addr;
                    pdata_n = word;
                end
            end
            ST_WRITE: begin
                if (is_halt) begin
`ifdef BIP_LOADER_CHECKSUM_EN
                    // checksum may already arrive during the halt write
                    if (rx_done)
                        state_n = sum_ok ? ST_RUN : ST_ERROR;
                    else
                        state_n = ST_CHECK;
`else
                    state_n = ST_RUN;
`endif
                end else if (at_max) begin
                    state_n = ST_ERROR;
                end else begin
                    addr_n  = addr + 1'b1;
                    state_n = ST_LOAD;
                    if (word_valid) begin
                        state_n = ST_WRITE;
                        wr_n    = 1'b1;
                        paddr_n = addr + 1'b1;
                        pdata_n = word;
                    end
                end
            end
`ifdef BIP_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (rx_done)
                    state_n = sum_ok ? ST_RUN : ST_ERROR;
            end
`endif
            ST_RUN:   state_n = ST_RUN;
            ST_ERROR: state_n = ST_ERROR;
            default:  state_n = ST_ERROR;
        endcase
        cpu_reset_n = (state_n != ST_RUN);
        done_n      = (state_n == ST_RUN);
        error_n     = (state_n == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LOAD;
            addr      <= '0;
            prog_wr   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            prog_wr   <= wr_n;
            prog_addr <= paddr_n;
            prog_data <= pdata_n;
            cpu_reset <= cpu_reset_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

`ifdef BIP_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            xsum <= '0;
        else
            xsum <= xsum_n;
    end
`endif

endmodule

// File: tb/tb_bip_program_loader.sv
// Directed bench for bip_program_loader: default instance plus a
// 2-bit address instance for the overflow case.
module tb_bip_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data, rx_data_s;
    logic        rx_done, rx_done_s;

    logic        prog_wr, cpu_reset, done, error;
    logic [10:0] prog_addr;
    logic [15:0] prog_data;

    logic        prog_wr_s, cpu_reset_s, done_s, error_s;
    logic [1:0]  prog_addr_s;
    logic [15:0] prog_data_s;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int wr_cnt_s = 0;
    int base;

    always #5 clk = ~clk;

    bip_program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .prog_wr  (prog_wr),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    bip_program_loader #(.ADDR_BITS(2)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data_s),
        .rx_done  (rx_done_s),
        .prog_wr  (prog_wr_s),
        .prog_addr(prog_addr_s),
        .prog_data(prog_data_s),
        .cpu_reset(cpu_reset_s),
        .done     (done_s),
        .error    (error_s)
    );

    always @(posedge clk) begin
        #1;
        if (prog_wr)   wr_cnt   = wr_cnt + 1;
        if (prog_wr_s) wr_cnt_s = wr_cnt_s + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        if (s) begin
            rx_data_s = b;
            rx_done_s = 1'b1;
        end else begin
            rx_data = b;
            rx_done = 1'b1;
        end
        @(negedge clk);
        rx_done   = 1'b0;
        rx_done_s = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // two bytes, then expect the write visible the cycle after the last
    task automatic load_word(input bit s, input logic [15:0] w,
                             input int a, input string tag);
        send(s, w[15:8]);
        idle(1);
        send(s, w[7:0]);
        if (s) begin
            check({tag, "_wr"},   32'(prog_wr_s),   32'd1);
            check({tag, "_addr"}, 32'(prog_addr_s), 32'(a));
            check({tag, "_data"}, 32'(prog_data_s), 32'(w));
        end else begin
            check({tag, "_wr"},   32'(prog_wr),   32'd1);
            check({tag, "_addr"}, 32'(prog_addr), 32'(a));
            check({tag, "_data"}, 32'(prog_data), 32'(w));
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx_data   = '0;
        rx_done   = 1'b0;
        rx_data_s = '0;
        rx_done_s = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        check("rst_wr",    32'(prog_wr),   32'd0);
        check("rst_addr",  32'(prog_addr), 32'd0);
        check("rst_data",  32'(prog_data), 32'd0);
        check("rst_cpu",   32'(cpu_reset), 32'd1);
        check("rst_done",  32'(done),      32'd0);
        check("rst_error", 32'(error),     32'd0);

        // basic three-word load
        load_word(0, 16'h1805, 0, "w0");
        idle(1);
        check("w0_pulse", 32'(prog_wr), 32'd0);
        load_word(0, 16'h2001, 1, "w1");
        idle(1);
        load_word(0, 16'h0000, 2, "halt");
        check("halt_done_early", 32'(done), 32'd0);
        check("halt_cpu_early", 32'(cpu_reset), 32'd1);
`ifdef BIP_LOADER_CHECKSUM_EN
        idle(1);
        check("chk_wait_done", 32'(done), 32'd0);
        send(0, 8'h3C);
`else
        idle(1);
`endif
        check("run_done",  32'(done),      32'd1);
        check("run_cpu",   32'(cpu_reset), 32'd0);
        check("run_wr",    32'(prog_wr),   32'd0);
        check("run_error", 32'(error),     32'd0);
        check("hold_addr", 32'(prog_addr), 32'd2);

        // bytes in RUN are ignored
        base = wr_cnt;
        send(0, 8'h12);
        idle(1);
        send(0, 8'h34);
        idle(2);
        check("run_nowr", 32'(wr_cnt), 32'(base));
        check("run_done_hold", 32'(done), 32'd1);

        // reset after 1.5 words, then reload only the halt word
        do_reset();
        load_word(0, 16'h1122, 0, "part");
        idle(1);
        send(0, 8'h33);
        idle(1);
        do_reset();
        check("rl_done0", 32'(done), 32'd0);
        check("rl_cpu1",  32'(cpu_reset), 32'd1);
        base = wr_cnt;
        load_word(0, 16'h0000, 0, "rl");
`ifdef BIP_LOADER_CHECKSUM_EN
        idle(1);
        send(0, 8'h00);
`else
        idle(1);
`endif
        check("rl_done", 32'(done), 32'd1);
        check("rl_one_wr", 32'(wr_cnt - base), 32'd1);

        // byte arriving during the WRITE cycle starts the next word
        do_reset();
        load_word(0, 16'h1122, 0, "p0");
        send(0, 8'hAB);
        idle(1);
        send(0, 8'hCD);
        check("p1_wr",   32'(prog_wr),   32'd1);
        check("p1_addr", 32'(prog_addr), 32'd1);
        check("p1_data", 32'(prog_data), 32'h0000ABCD);
        idle(1);
        load_word(0, 16'h0000, 2, "p_halt");
`ifdef BIP_LOADER_CHECKSUM_EN
        idle(1);
        send(0, 8'h55);
`else
        idle(1);
`endif
        check("p_done", 32'(done), 32'd1);

        // 2-bit address: four non-halt words overflow into ERROR
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_word(1, {8'(i + 1), 8'(i + 1)}, i, "s");
            idle(1);
        end
        check("s_wrcount", 32'(wr_cnt_s), 32'd4);
        check("s_error",   32'(error_s),  32'd1);
        check("s_cpu",     32'(cpu_reset_s), 32'd1);
        check("s_done",    32'(done_s),   32'd0);
        base = wr_cnt_s;
        for (int i = 0; i < 4; i++) begin
            send(1, 8'h00);
            idle(1);
        end
        check("s_nowr",      32'(wr_cnt_s), 32'(base));
        check("s_error_hold", 32'(error_s), 32'd1);
        check("s_hold_addr", 32'(prog_addr_s), 32'd3);
        check("s_hold_data", 32'(prog_data_s), 32'h00000404);

`ifdef BIP_LOADER_CHECKSUM_EN
        // matching checksum
        do_reset();
        load_word(0, 16'h1234, 0, "c0");
        idle(1);
        load_word(0, 16'h0000, 1, "c1");
        idle(1);
        send(0, 8'h26);
        check("cs_ok_done",  32'(done),  32'd1);
        check("cs_ok_error", 32'(error), 32'd0);

        // wrong checksum
        do_reset();
        load_word(0, 16'h1234, 0, "d0");
        idle(1);
        load_word(0, 16'h0000, 1, "d1");
        idle(1);
        send(0, 8'h27);
        check("cs_bad_error", 32'(error),     32'd1);
        check("cs_bad_cpu",   32'(cpu_reset), 32'd1);
        check("cs_bad_done",  32'(done),      32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
